if_fetch_ctrl: RTL and testbench
================================

// Module: if_fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer that replaces the free-running PC register. It owns the fetch PC,
//  issues one-at-a-time req/gnt/rvalid transactions to instruction memory, and applies trap/branch
//  redirects, discarding stale responses. Fetched words go through a small buffer to decode,
//  using valid/ready.
// PARAMETERS
//  RESET_PC   32'h0000_0000  fetch address after reset
//  BUF_DEPTH  2              instruction buffer entries (power of 2, >=2)
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   asynchronous, active-low reset
//  trap_flag_i    in   1   redirect pulse from CSR/trap unit (highest priority)
//  trap_addr_i    in   32  trap target
//  branch_flag_i  in   1   redirect pulse from execute
//  branch_addr_i  in   32  branch/jump target
//  ibus_req_o     out  1   fetch request
//  ibus_addr_o    out  32  fetch address, word aligned
//  ibus_gnt_i     in   1   request accepted this cycle
//  ibus_rvalid_i  in   1   read data valid (one per granted request, >=1 cycle after gnt)
//  ibus_rdata_i   in   32  instruction word
//  inst_valid_o   out  1   buffer head valid to decode
//  inst_o         out  32  buffer head instruction
//  inst_addr_o    out  32  PC of inst_o
//  id_ready_i     in   1   decode consumes head when inst_valid_o & id_ready_i
// BEHAVIOUR
//  Reset (rst==0, async): state=BOOT, fetch_pc=RESET_PC, buffer empty; ibus_req_o=0, ibus_addr_o=RESET_PC,
//   inst_valid_o=0, inst_o=0, inst_addr_o=0. First req asserts the 2nd rising edge after rst deasserts.
//  FSM states: BOOT -> REQ (unconditional, 1 cycle).
//   REQ: ibus_req_o=1 iff (count + 0) < BUF_DEPTH; ibus_addr_o=fetch_pc. On req&gnt -> WAIT, fetch_pc+=4.
//   WAIT: ibus_req_o=0. On rvalid -> push {fetch_pc-4, rdata} into buffer, go to REQ.
//   FLUSH: ibus_req_o=0. On rvalid -> drop data, go to REQ. fetch_pc already holds the redirect target.
//  Outstanding limit: at most 1 granted-but-unanswered request. Issue only if the buffer has a free
//   slot for its response (count < BUF_DEPTH, counting no pushes in flight).
//  Redirect: redir = trap_flag_i | branch_flag_i; target = trap ? trap_addr_i : branch_addr_i;
//   target[1:0] forced to 2'b00. Effect in the redirect cycle N:
//   - fetch_pc <= target; buffer flushed (inst_valid_o=0 from N+1); pop at N is still honoured.
//   - REQ without gnt at N: request abandoned (req may drop/change addr before gnt); req(target) at N+1.
//   - REQ with gnt at N, or WAIT without rvalid at N: -> FLUSH (response stale).
//   - WAIT with rvalid at N: data dropped, -> REQ; req(target) at N+1.
//   - FLUSH at N: stays FLUSH (or -> REQ if rvalid at N); fetch_pc takes the newest target.
//  Latency: redirect at N with nothing outstanding -> req(target) at N+1; rvalid at M -> inst_valid_o at M+1.
//  Buffer: FIFO; push and pop in the same cycle are both allowed when full (pop frees the slot next
//   cycle only, so req is not raised on the full->pop cycle). Pointers wrap mod BUF_DEPTH.
//  Arithmetic: fetch_pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). No error on wrap.
//  Outputs inst_o/inst_addr_o are driven from the buffer head; they are undefined-free (hold last) when empty.
//  Reset mid-transaction: all state cleared at once; any later rvalid from the old request while in BOOT/REQ
//   is ignored (bus is reset by the same rst).
// STRUCTURE
//  bitty_defs.v gains: `FetchBoot/`FetchReq/`FetchWait/`FetchFlush (2-bit encodings),
//   `RstActiveLow (1'b0), plus the existing `InstAddrBus/`InstBus/`ZeroWord widths.
//  Sub-module if_inst_buf: BUF_DEPTH x 64-bit {pc,inst} FIFO with flush, push, pop, count, full, empty.
//  Top: FSM + fetch_pc register + redirect mux. Estimated 200-300 lines.
// TESTING
//  1 Reset release, zero-wait memory (gnt same cycle, rvalid +1), ready=1 -> addresses 0,4,8,.. and
//    inst_addr_o follows in order, with one instruction per 2 cycles.
//  2 id_ready_i=0 for 10 cycles -> buffer fills to 2 and req stays low; on ready=1, 2 pops occur back-to-back.
//  3 branch_flag_i=1, addr 0x100, while in WAIT -> FLUSH; the stale rvalid is dropped; next req addr=0x100;
//    first delivered inst_addr_o=0x100.
//  4 trap (0x80) and branch (0x200) in the same cycle -> next fetch addr 0x80. branch_addr 0x103 -> fetch 0x100.
//  5 Redirect in the same cycle as gnt, and separately in the same cycle as rvalid -> no stale word reaches decode.
//  6 RESET_PC=32'hFFFF_FFF8 -> fetches FFFF_FFF8, FFFF_FFFC, 0000_0000; rst pulsed low in WAIT -> outputs reset
//    immediately, restart at RESET_PC.

Source files
------------

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package if_fetch_ctrl_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_WAIT  = 2'd2,
    FETCH_FLUSH = 2'd3
  } fetch_state_e;

  // One buffered fetch: the PC it came from and the word returned.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Clear the byte offset so every fetch address is word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_buf.sv
// Small {pc,inst} FIFO between the fetch bus and decode, with flush.
module if_fetch_ctrl_buf
  import if_fetch_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output logic                   valid,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count_nxt_c
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_nxt_c;
  logic [CW-1:0]   count;
  logic [CW-1:0]   remain_c;
  logic            full_c;
  logic            do_push_c;
  logic            do_pop_c;

  // A pop while full makes room for a push in the same cycle.
  assign full_c      = (count == CW'(DEPTH));
  assign do_pop_c    = pop & (count != '0);
  assign do_push_c   = push & (~full_c | do_pop_c) & ~flush;
  assign remain_c    = count - CW'(do_pop_c);
  assign rd_nxt_c    = rd_ptr + PW'(do_pop_c);
  assign count_nxt_c = flush ? '0 : remain_c + CW'(do_push_c);

  // Storage array; contents are only observed through the head register.
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and registered head; head holds its last value when empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      head   <= '0;
    end else begin
      count <= count_nxt_c;
      valid <= (count_nxt_c != '0);
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        rd_ptr <= rd_nxt_c;
        wr_ptr <= wr_ptr + PW'(do_push_c);
        if (remain_c == '0) begin
          if (do_push_c) head <= push_data;
        end else begin
          head <= mem[rd_nxt_c];
        end
      end
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, runs one req/gnt/rvalid
// transaction at a time, applies trap/branch redirects and drops stale data.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_flag_i,
  input  logic [XLEN-1:0] trap_addr_i,
  input  logic            branch_flag_i,
  input  logic [XLEN-1:0] branch_addr_i,
  output logic            ibus_req_o,
  output logic [XLEN-1:0] ibus_addr_o,
  input  logic            ibus_gnt_i,
  input  logic            ibus_rvalid_i,
  input  logic [XLEN-1:0] ibus_rdata_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  input  logic            id_ready_i
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e    state;
  fetch_state_e    state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] redir_tgt_c;
  logic            redir_c;
  logic            grant_c;
  logic            push_c;
  logic            pop_c;
  logic            req_nxt;
  logic [CW-1:0]   count_nxt_c;
  fetch_entry_t    push_data_c;
  fetch_entry_t    head;

  // Redirect select: trap outranks branch.
  assign redir_c     = trap_flag_i | branch_flag_i;
  assign redir_tgt_c = word_align(trap_flag_i ? trap_addr_i : branch_addr_i);
  assign grant_c     = ibus_req_o & ibus_gnt_i;
  assign pop_c       = inst_valid_o & id_ready_i;

  // A response is kept only in WAIT and only if no redirect lands with it.
  assign push_c           = (state == FETCH_WAIT) & ibus_rvalid_i & ~redir_c;
  assign push_data_c.pc   = fetch_pc - XLEN'(PC_STEP);
  assign push_data_c.inst = ibus_rdata_i;

  // Request only once past BOOT and only with a free slot for the reply.
  assign req_nxt = (state_nxt == FETCH_REQ) && (state != FETCH_BOOT) &&
                   (count_nxt_c < CW'(BUF_DEPTH));

  assign ibus_addr_o = fetch_pc;
  assign inst_o      = head.inst;
  assign inst_addr_o = head.pc;

  // Next-state and next-PC; a redirect always wins the PC.
  always_comb begin
    state_nxt = state;
    pc_nxt    = fetch_pc;
    case (state)
      FETCH_BOOT: state_nxt = FETCH_REQ;
      FETCH_REQ: begin
        if (grant_c) begin
          pc_nxt    = fetch_pc + XLEN'(PC_STEP);
          state_nxt = redir_c ? FETCH_FLUSH : FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (ibus_rvalid_i)  state_nxt = FETCH_REQ;
        else if (redir_c)   state_nxt = FETCH_FLUSH;
      end
      FETCH_FLUSH: begin
        if (ibus_rvalid_i) state_nxt = FETCH_REQ;
      end
      default: state_nxt = FETCH_BOOT;
    endcase
    if (redir_c) pc_nxt = redir_tgt_c;
  end

  // State, fetch PC and registered request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FETCH_BOOT;
      fetch_pc   <= RESET_PC;
      ibus_req_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      fetch_pc   <= pc_nxt;
      ibus_req_o <= req_nxt;
    end
  end

  if_fetch_ctrl_buf #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .flush       (redir_c),
    .push        (push_c),
    .push_data   (push_data_c),
    .pop         (pop_c),
    .valid       (inst_valid_o),
    .head        (head),
    .count_nxt_c (count_nxt_c)
  );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Randomized bench for if_fetch_ctrl with a transaction-level reference model.
module tb_if_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_flag_i, branch_flag_i;
  logic [31:0] trap_addr_i, branch_addr_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i, ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o, inst_addr_o;
  logic        id_ready_i;

  always #5 clk = ~clk;

  if_fetch_ctrl #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .trap_flag_i   (trap_flag_i),
    .trap_addr_i   (trap_addr_i),
    .branch_flag_i (branch_flag_i),
    .branch_addr_i (branch_addr_i),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_addr_o   (inst_addr_o),
    .id_ready_i    (id_ready_i)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: next address expected on the bus, next PC expected at
  // decode, buffer occupancy, one outstanding transaction and its staleness.
  logic [31:0] m_fetch, m_deliver;
  int          m_occ, m_age, n_pop;
  bit          m_out, m_stale;

  // Memory model: one pending read with a random response latency.
  bit          b_pend;
  int          b_lat;
  logic [31:0] b_addr;

  // Stimulus knobs and one-shot forced redirect.
  int          gnt_pct, rdy_pct, redir_pct, max_lat;
  int          force_mode;
  bit          f_trap, f_branch;
  logic [31:0] f_taddr, f_baddr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5EED_F00D;
  endfunction

  function automatic logic [31:0] rand_target();
    if ($urandom_range(3) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(15));
    return $urandom;
  endfunction

  task automatic drive_idle();
    trap_flag_i   = 1'b0;
    branch_flag_i = 1'b0;
    trap_addr_i   = '0;
    branch_addr_i = '0;
    ibus_gnt_i    = 1'b0;
    ibus_rvalid_i = 1'b0;
    ibus_rdata_i  = '0;
    id_ready_i    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    #1;
    chk("rst_req", 32'(ibus_req_o), 32'd0);
    chk("rst_addr", ibus_addr_o, RST_PC);
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_inst_addr", inst_addr_o, 32'd0);
    repeat (2) @(negedge clk);
    rst       = 1'b1;
    m_fetch   = RST_PC;
    m_deliver = RST_PC;
    m_occ     = 0;
    m_out     = 1'b0;
    m_stale   = 1'b0;
    m_age     = 1;
    b_pend    = 1'b0;
  endtask

  // One clock: check registered outputs, drive inputs, advance the model.
  task automatic step();
    bit          grant, rv_done, redir, pop, push, hit;
    logic [31:0] tgt;
    @(negedge clk);
    chk("req", 32'(ibus_req_o), 32'((m_age >= 2) && !m_out && (m_occ < DEPTH)));
    if (ibus_req_o) chk("req_addr", ibus_addr_o, m_fetch);
    chk("valid", 32'(inst_valid_o), 32'(m_occ > 0));

    ibus_gnt_i    = ibus_req_o && (int'($urandom_range(99)) < gnt_pct);
    ibus_rvalid_i = 1'b0;
    ibus_rdata_i  = $urandom;
    if (b_pend) begin
      b_lat--;
      if (b_lat == 0) begin
        ibus_rvalid_i = 1'b1;
        ibus_rdata_i  = mem_word(b_addr);
      end
    end
    id_ready_i    = (int'($urandom_range(99)) < rdy_pct);
    trap_flag_i   = (int'($urandom_range(199)) < redir_pct);
    branch_flag_i = (int'($urandom_range(199)) < redir_pct);
    trap_addr_i   = rand_target();
    branch_addr_i = rand_target();

    grant   = ibus_gnt_i;
    rv_done = ibus_rvalid_i && m_out;
    case (force_mode)
      1:       hit = m_out && !ibus_rvalid_i;
      2:       hit = grant;
      3:       hit = rv_done;
      4:       hit = 1'b1;
      default: hit = 1'b0;
    endcase
    if (hit) begin
      trap_flag_i   = f_trap;
      branch_flag_i = f_branch;
      trap_addr_i   = f_taddr;
      branch_addr_i = f_baddr;
      force_mode    = 0;
    end
    redir = trap_flag_i || branch_flag_i;
    tgt   = (trap_flag_i ? trap_addr_i : branch_addr_i) & 32'hFFFF_FFFC;

    pop = inst_valid_o && id_ready_i;
    if (pop) begin
      chk("inst_addr", inst_addr_o, m_deliver);
      chk("inst", inst_o, mem_word(m_deliver));
      m_deliver += 32'd4;
      n_pop++;
    end
    if (redir) m_deliver = tgt;

    push  = rv_done && !m_stale && !redir;
    m_occ = redir ? 0 : m_occ - int'(pop) + int'(push);

    if (grant) begin
      b_pend  = 1'b1;
      b_lat   = int'($urandom_range(max_lat, 1));
      b_addr  = m_fetch;
      m_out   = 1'b1;
      m_stale = redir;
      m_fetch += 32'd4;
    end else if (m_out && !rv_done && redir) begin
      m_stale = 1'b1;
    end
    if (rv_done) begin
      m_out  = 1'b0;
      b_pend = 1'b0;
    end
    if (redir) m_fetch = tgt;
    m_age++;
  endtask

  task automatic force_redirect(input int mode, input bit tr, input logic [31:0] ta,
                                input bit br, input logic [31:0] ba);
    force_mode = mode;
    f_trap     = tr;
    f_taddr    = ta;
    f_branch   = br;
    f_baddr    = ba;
    for (int i = 0; i < 60 && force_mode != 0; i++) step();
    chk("force_hit", 32'(force_mode), 32'd0);
    force_mode = 0;
    repeat (12) step();
  endtask

  initial begin
    rst        = 1'b0;
    force_mode = 0;
    drive_idle();
    do_reset();

    // Zero-wait memory, decode always ready: one instruction per two cycles.
    gnt_pct = 100; rdy_pct = 100; redir_pct = 0; max_lat = 1;
    n_pop = 0;
    repeat (30) step();
    chk("stream_pops", 32'(n_pop), 32'd14);

    // Decode stalls: buffer fills and requests stop; then drains back-to-back.
    rdy_pct = 0;
    repeat (12) step();
    rdy_pct = 100;
    repeat (10) step();

    // Directed redirects against slow memory.
    max_lat = 3;
    force_redirect(1, 1'b0, 32'h0, 1'b1, 32'h0000_0100);
    force_redirect(4, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0200);
    force_redirect(4, 1'b0, 32'h0, 1'b1, 32'h0000_0103);
    force_redirect(2, 1'b0, 32'h0, 1'b1, 32'h0000_0400);
    force_redirect(3, 1'b1, 32'h0000_0600, 1'b0, 32'h0);
    force_redirect(4, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8);

    // Randomized traffic with occasional reset in the middle of a transaction.
    for (int blk = 0; blk < 24; blk++) begin
      gnt_pct   = int'($urandom_range(100, 30));
      rdy_pct   = int'($urandom_range(100, 0));
      redir_pct = int'($urandom_range(15, 0));
      max_lat   = int'($urandom_range(4, 1));
      repeat (120) step();
      if (blk == 8 || blk == 16) begin
        gnt_pct = 100;
        max_lat = 3;
        for (int i = 0; i < 40 && !(b_pend && b_lat > 1); i++) step();
        chk("reset_in_wait", 32'(b_pend), 32'd1);
        do_reset();
        repeat (6) step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
